// File: rtl/spi_wdt_pkg.sv
// spi_wdt_pkg: shared register map, bit indices
// and watchdog state encoding.
package spi_wdt_pkg;

  localparam int ADDR_CTRL   = 0;
  localparam int ADDR_TMO_LO = 1;
  localparam int ADDR_TMO_HI = 2;
  localparam int ADDR_PRESC  = 3;
  localparam int ADDR_KICK   = 4;
  localparam int ADDR_CNT_LO = 5;
  localparam int ADDR_CNT_HI = 6;
  localparam int ADDR_STATUS = 7;

  localparam int CTRL_EN   = 0;
  localparam int CTRL_LOCK = 1;

  localparam int ST_RUN = 0;
  localparam int ST_EXP = 1;
  localparam int ST_BAD = 2;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUNNING  = 2'd1,
    EXPIRED  = 2'd2
  } wdt_state_t;

endpackage

// File: rtl/wdt_prescaler.sv
// wdt_prescaler: divides clk by (prescale+1)
// while run is high; clear restarts the divider.
module wdt_prescaler (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       clear,
  input  logic [7:0] prescale,
  output logic       tick
);

  logic [7:0] pcnt_d, pcnt_q;

  assign tick = run && (pcnt_q == prescale);

  // next divider count: wrap on tick, hold at 0 when idle
  always_comb begin
    pcnt_d = pcnt_q + 8'd1;
    if (!run || clear || tick) pcnt_d = 8'd0;
  end

  // divider register
  always_ff @(posedge clk) begin
    if (rst) pcnt_q <= 8'd0;
    else     pcnt_q <= pcnt_d;
  end

endmodule

// File: rtl/spi_wdt_regs.sv
// spi_wdt_regs: SPI-side register bank and
// prescaled 16-bit down-counting watchdog.
module spi_wdt_regs
  import spi_wdt_pkg::*;
#(
  parameter int         ADDR_W     = 3,
  parameter int         REG_W      = 8,
  parameter logic [7:0] KICK_MAGIC = 8'hA5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] reg_addr,
  input  logic [REG_W-1:0]  reg_data_o,
  input  logic              reg_data_o_dv,
  input  logic              reg_addr_v,
  output logic [REG_W-1:0]  reg_data_i,
  output logic [7:0]        status,
  output logic              wdt_bite
);

  wdt_state_t  state_d, state_q;
  logic        en_d, en_q;
  logic        lock_d, lock_q;
  logic [15:0] tmo_d, tmo_q;
  logic [7:0]  pre_d, pre_q;
  logic [15:0] cnt_d, cnt_q;
  logic [7:0]  snap_d, snap_q;
  logic        bad_d, bad_q;
  logic [7:0]  status_d, status_q;
  logic        rv_q;

  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        wr_ctrl, wr_tlo, wr_thi;
  logic        wr_pre, wr_kick, wr_stat;
  logic        kick, dis, reload, tick;

  assign wdata   = reg_data_o[7:0];
  assign wr_ctrl = reg_data_o_dv &&
                   (reg_addr == ADDR_W'(ADDR_CTRL));
  assign wr_tlo  = reg_data_o_dv &&
                   (reg_addr == ADDR_W'(ADDR_TMO_LO));
  assign wr_thi  = reg_data_o_dv &&
                   (reg_addr == ADDR_W'(ADDR_TMO_HI));
  assign wr_pre  = reg_data_o_dv &&
                   (reg_addr == ADDR_W'(ADDR_PRESC));
  assign wr_kick = reg_data_o_dv &&
                   (reg_addr == ADDR_W'(ADDR_KICK));
  assign wr_stat = reg_data_o_dv &&
                   (reg_addr == ADDR_W'(ADDR_STATUS));
  assign kick    = wr_kick && (wdata == KICK_MAGIC);

  wdt_prescaler u_presc (
    .clk      (clk),
    .rst      (rst),
    .run      (state_q == RUNNING),
    .clear    (reload),
    .prescale (pre_q),
    .tick     (tick)
  );

  // register writes, watchdog next state and status
  always_comb begin
    en_d    = en_q;
    lock_d  = lock_q;
    tmo_d   = tmo_q;
    pre_d   = pre_q;
    cnt_d   = cnt_q;
    bad_d   = bad_q;
    state_d = state_q;
    snap_d  = snap_q;
    reload  = 1'b0;
    if (wr_ctrl) begin
      lock_d = lock_q | wdata[CTRL_LOCK];
      en_d   = lock_q ? (en_q | wdata[CTRL_EN])
                      : wdata[CTRL_EN];
    end
    if (wr_tlo && !lock_q) tmo_d[7:0]  = wdata;
    if (wr_thi && !lock_q) tmo_d[15:8] = wdata;
    if (wr_pre && !lock_q) pre_d       = wdata;
    // set beats clear when both land together
    if (wr_stat && wdata[ST_BAD]) bad_d = 1'b0;
    if (wr_kick && !kick)         bad_d = 1'b1;
    dis = wr_ctrl && !en_d;
    unique case (state_q)
      DISABLED: begin
        if (wr_ctrl && en_d) begin
          state_d = RUNNING;
          reload  = 1'b1;
        end
      end
      RUNNING: begin
        if (dis) begin
          state_d = DISABLED;
        end else if (kick) begin
          reload = 1'b1;
        end else if (tick) begin
          if (cnt_q == 16'd0) state_d = EXPIRED;
          else                cnt_d   = cnt_q - 16'd1;
        end
      end
      EXPIRED: begin
        if (dis) begin
          state_d = DISABLED;
        end else if (wr_stat && wdata[ST_EXP] && en_q) begin
          state_d = RUNNING;
          reload  = 1'b1;
        end
      end
      default: state_d = DISABLED;
    endcase
    if (reload) cnt_d = tmo_q;
    if (reg_addr_v && !rv_q &&
        (reg_addr == ADDR_W'(ADDR_CNT_LO)))
      snap_d = cnt_q[15:8];
    status_d = {5'b0, bad_d,
                state_d == EXPIRED,
                state_d == RUNNING};
  end

  // state and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= DISABLED;
      en_q     <= 1'b0;
      lock_q   <= 1'b0;
      tmo_q    <= 16'hFFFF;
      pre_q    <= 8'd0;
      cnt_q    <= 16'hFFFF;
      snap_q   <= 8'd0;
      bad_q    <= 1'b0;
      status_q <= 8'd0;
      rv_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      en_q     <= en_d;
      lock_q   <= lock_d;
      tmo_q    <= tmo_d;
      pre_q    <= pre_d;
      cnt_q    <= cnt_d;
      snap_q   <= snap_d;
      bad_q    <= bad_d;
      status_q <= status_d;
      rv_q     <= reg_addr_v;
    end
  end

  // combinational read mux
  always_comb begin
    rdata = 8'd0;
    case (reg_addr)
      ADDR_W'(ADDR_CTRL):   rdata = {6'b0, lock_q, en_q};
      ADDR_W'(ADDR_TMO_LO): rdata = tmo_q[7:0];
      ADDR_W'(ADDR_TMO_HI): rdata = tmo_q[15:8];
      ADDR_W'(ADDR_PRESC):  rdata = pre_q;
      ADDR_W'(ADDR_CNT_LO): rdata = cnt_q[7:0];
      ADDR_W'(ADDR_CNT_HI): rdata = snap_q;
      ADDR_W'(ADDR_STATUS): rdata = status_q;
      default:              rdata = 8'd0;
    endcase
  end

  assign reg_data_i = REG_W'(rdata);
  assign status     = status_q;
  assign wdt_bite   = status_q[ST_EXP];

endmodule

// File: tb/tb_spi_wdt_regs.sv
// tb_spi_wdt_regs: directed checks of the
// watchdog register bank.
module tb_spi_wdt_regs;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] reg_addr;
  logic [7:0] reg_data_o;
  logic       reg_data_o_dv;
  logic       reg_addr_v;
  logic [7:0] reg_data_i;
  logic [7:0] status;
  logic       wdt_bite;

  int ncmp  = 0;
  int nfail = 0;

  logic [7:0] rst_rd [8] = '{8'h00, 8'hFF, 8'hFF, 8'h00,
                             8'h00, 8'hFF, 8'hFF, 8'h00};

  spi_wdt_regs dut (
    .clk           (clk),
    .rst           (rst),
    .reg_addr      (reg_addr),
    .reg_data_o    (reg_data_o),
    .reg_data_o_dv (reg_data_o_dv),
    .reg_addr_v    (reg_addr_v),
    .reg_data_i    (reg_data_i),
    .status        (status),
    .wdt_bite      (wdt_bite)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] req);
    ncmp++;
    assert (obs === req) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h",
             tag, obs, req);
    end
  endtask

  task automatic wr(input logic [2:0] a,
                    input logic [7:0] d);
    reg_addr      = a;
    reg_data_o    = d;
    reg_data_o_dv = 1'b1;
    step();
    reg_data_o_dv = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a,
                    input logic [7:0] req,
                    input string tag);
    reg_addr = a;
    #1;
    chk(tag, reg_data_i, req);
  endtask

  initial begin
    rst           = 1'b1;
    reg_addr      = 3'd0;
    reg_data_o    = 8'd0;
    reg_data_o_dv = 1'b0;
    reg_addr_v    = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_status", status, 8'h00);
    chk("rst_bite", {7'b0, wdt_bite}, 8'h00);
    for (int a = 0; a < 8; a++) begin
      reg_addr   = 3'(a);
      reg_addr_v = 1'b1;
      step();
      chk($sformatf("rst_rd%0d", a), reg_data_i, rst_rd[a]);
      reg_addr_v = 1'b0;
      step();
    end

    // TIMEOUT=3, PRESCALE=1: bite after 8 cycles
    wr(3'd1, 8'h03);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h01);
    wr(3'd0, 8'h01);
    chk("en_status", status, 8'h01);
    repeat (7) step();
    chk("bite_c7", {7'b0, wdt_bite}, 8'h00);
    step();
    chk("bite_c8", {7'b0, wdt_bite}, 8'h01);
    chk("exp_status", status, 8'h02);
    rd(3'd5, 8'h00, "exp_cnt");

    // restart, then periodic kicks
    wr(3'd7, 8'h02);
    chk("restart_st", status, 8'h01);
    rd(3'd5, 8'h03, "restart_cnt");
    for (int k = 0; k < 17; k++) begin
      wr(3'd4, 8'hA5);
      repeat (5) step();
      chk($sformatf("kick%0d", k), {7'b0, wdt_bite}, 8'h00);
    end
    wr(3'd4, 8'h5A);
    chk("badkick_set", status, 8'h05);
    wr(3'd4, 8'hA5);
    chk("badkick_hold", status, 8'h05);
    wr(3'd7, 8'h04);
    chk("badkick_clr", status, 8'h01);

    // lock blocks disable and timeout writes
    wr(3'd0, 8'h03);
    rd(3'd0, 8'h03, "lock_rd");
    wr(3'd0, 8'h00);
    rd(3'd0, 8'h03, "lock_ctrl");
    chk("lock_st", status, 8'h01);
    wr(3'd1, 8'h10);
    rd(3'd1, 8'h03, "lock_tmo");
    for (int i = 0; i < 20 && !wdt_bite; i++) step();
    chk("lock_expire", {7'b0, wdt_bite}, 8'h01);
    wr(3'd7, 8'h02);
    chk("lock_rerun", status, 8'h01);
    rd(3'd5, 8'h03, "lock_reload");

    // kick on the tick at count 0
    repeat (7) step();
    rd(3'd5, 8'h00, "zero_cnt");
    chk("zero_st", status, 8'h01);
    wr(3'd4, 8'hA5);
    chk("zkick_st", status, 8'h01);
    chk("zkick_bite", {7'b0, wdt_bite}, 8'h00);
    rd(3'd5, 8'h03, "zkick_cnt");
    for (int i = 0; i < 20 && !wdt_bite; i++) step();
    chk("zkick_expire", {7'b0, wdt_bite}, 8'h01);

    // reset while expired
    rst = 1'b1;
    step();
    chk("mrst_bite", {7'b0, wdt_bite}, 8'h00);
    chk("mrst_st", status, 8'h00);
    rd(3'd0, 8'h00, "mrst_ctrl");
    rst = 1'b0;

    // COUNT_HI snapshot coherence
    wr(3'd1, 8'hFF);
    wr(3'd2, 8'h01);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h01);
    reg_addr   = 3'd5;
    reg_addr_v = 1'b1;
    step();
    rd(3'd5, 8'hFE, "snap_lo0");
    rd(3'd6, 8'h01, "snap_hi0");
    repeat (300) step();
    rd(3'd5, 8'hD2, "snap_lo1");
    rd(3'd6, 8'h01, "snap_hi1");
    reg_addr_v = 1'b0;
    step();
    reg_addr   = 3'd5;
    reg_addr_v = 1'b1;
    step();
    rd(3'd6, 8'h00, "snap_hi2");
    reg_addr_v = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
